// File: rtl/blake2s_round_sched.sv
// rtl/blake2s_round_sched.sv - BLAKE2s compression round scheduler around a single G unit
module blake2s_round_sched #(
  parameter int ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         ready,
  input  logic [511:0] v_in,
  input  logic [511:0] m_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] v_out,
  output logic [3:0]   round_o,
  output logic [2:0]   step_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

  state_t       state_q, state_d;
  logic [511:0] v_q, m_q, v_wb;
  logic [3:0]   round_q;
  logic [2:0]   step_q;
  logic         out_valid_q;
  logic         last_step;
  logic         handshake;

  logic [3:0]   ia, ib, ic, id;
  logic [3:0]   mx, my;
  logic [31:0]  a_i, b_i, c_i, d_i, x_i, y_i;
  logic [127:0] g_out;

  // Each SIGMA row is packed with entry 0 in the top nibble, so entry i
  // sits at nibble (15 - i), which for a 4-bit index is simply ~i.
  function automatic logic [3:0] sigma(input logic [3:0] r, input logic [3:0] i);
    logic [63:0] row;
    case (r)
      4'd1:    row = 64'hEA489FD61C02B753;
      4'd2:    row = 64'hB8C052FDAE367194;
      4'd3:    row = 64'h7931DCBE265A40F8;
      4'd4:    row = 64'h905724AFE1BC683D;
      4'd5:    row = 64'h2C6A0B834D75FE19;
      4'd6:    row = 64'hC51FED4A0763928B;
      4'd7:    row = 64'hDB7EC13950F4862A;
      4'd8:    row = 64'h6FE9B308C2D714A5;
      4'd9:    row = 64'hA2847615FB9E3CD0;
      default: row = 64'h0123456789ABCDEF;
    endcase
    return row[{~i, 2'b00} +: 4];
  endfunction

  // BLAKE2s quarter-round; returns {a_o, b_o, c_o, d_o}. Adds wrap mod 2^32.
  function automatic logic [127:0] g_fn(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c, input logic [31:0] d,
                                        input logic [31:0] x, input logic [31:0] y);
    logic [31:0] t;
    a = a + b + x;
    t = d ^ a;  d = {t[15:0], t[31:16]};
    c = c + d;
    t = b ^ c;  b = {t[11:0], t[31:12]};
    a = a + b + y;
    t = d ^ a;  d = {t[7:0], t[31:8]};
    c = c + d;
    t = b ^ c;  b = {t[6:0], t[31:7]};
    return {a, b, c, d};
  endfunction

  assign last_step = (round_q == LAST_ROUND) && (step_q == 3'd7);
  assign handshake = out_valid_q && out_ready;

  // Column steps 0..3, then diagonal steps 4..7 of the 4x4 working matrix.
  always_comb begin
    ia = 4'd0; ib = 4'd4; ic = 4'd8; id = 4'd12;
    case (step_q)
      3'd0: begin ia = 4'd0; ib = 4'd4; ic = 4'd8;  id = 4'd12; end
      3'd1: begin ia = 4'd1; ib = 4'd5; ic = 4'd9;  id = 4'd13; end
      3'd2: begin ia = 4'd2; ib = 4'd6; ic = 4'd10; id = 4'd14; end
      3'd3: begin ia = 4'd3; ib = 4'd7; ic = 4'd11; id = 4'd15; end
      3'd4: begin ia = 4'd0; ib = 4'd5; ic = 4'd10; id = 4'd15; end
      3'd5: begin ia = 4'd1; ib = 4'd6; ic = 4'd11; id = 4'd12; end
      3'd6: begin ia = 4'd2; ib = 4'd7; ic = 4'd8;  id = 4'd13; end
      default: begin ia = 4'd3; ib = 4'd4; ic = 4'd9; id = 4'd14; end
    endcase
  end

  // Operand and message-word selection, G evaluation and write-back merge.
  always_comb begin
    mx    = sigma(round_q, {step_q, 1'b0});
    my    = sigma(round_q, {step_q, 1'b1});
    a_i   = v_q[{ia, 5'b0} +: 32];
    b_i   = v_q[{ib, 5'b0} +: 32];
    c_i   = v_q[{ic, 5'b0} +: 32];
    d_i   = v_q[{id, 5'b0} +: 32];
    x_i   = m_q[{mx, 5'b0} +: 32];
    y_i   = m_q[{my, 5'b0} +: 32];
    g_out = g_fn(a_i, b_i, c_i, d_i, x_i, y_i);
    v_wb  = v_q;
    v_wb[{ia, 5'b0} +: 32] = g_out[127:96];
    v_wb[{ib, 5'b0} +: 32] = g_out[95:64];
    v_wb[{ic, 5'b0} +: 32] = g_out[63:32];
    v_wb[{id, 5'b0} +: 32] = g_out[31:0];
  end

  // Next-state logic; start is only honoured in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)     state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    if (handshake) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Working vector, message block and round/step counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q     <= '0;
      m_q     <= '0;
      round_q <= 4'd0;
      step_q  <= 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            v_q     <= v_in;
            m_q     <= m_in;
            round_q <= 4'd0;
            step_q  <= 3'd0;
          end
        end
        RUN: begin
          v_q <= v_wb;
          if (last_step) begin
            round_q <= 4'd0;
            step_q  <= 3'd0;
          end else if (step_q == 3'd7) begin
            round_q <= round_q + 4'd1;
            step_q  <= 3'd0;
          end else begin
            step_q  <= step_q + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Valid is registered one cycle after entering DONE and clears on handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_valid_q <= 1'b0;
    else     out_valid_q <= (state_q == DONE) && !handshake;
  end

  assign ready     = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign v_out     = v_q;
  assign round_o   = round_q;
  assign step_o    = step_q;

endmodule
